// File: rtl/dac_sample_feed_if.sv
// Read-side FIFO handshake, DAC output and debug status for dac_sample_feed.
// The slave modport is the feeder; the master modport is the FIFO/DAC side.
interface dac_sample_feed_if #(
    parameter int DATA_W  = 16,
    parameter int DAC_W   = 14,
    parameter int USEDW_W = 11
);
    logic               enable;
    logic               rdempty;
    logic [USEDW_W-1:0] rdusedw;
    logic [DATA_W-1:0]  q;
    logic               rdreq;
    logic [DAC_W-1:0]   dac_data;
    logic               dac_valid;
    logic [1:0]         feed_state;
    logic [15:0]        underrun_cnt;
    logic [31:0]        sample_cnt;

    modport master (
        output enable, rdempty, rdusedw, q,
        input  rdreq, dac_data, dac_valid, feed_state, underrun_cnt, sample_cnt
    );

    modport slave (
        input  enable, rdempty, rdusedw, q,
        output rdreq, dac_data, dac_valid, feed_state, underrun_cnt, sample_cnt
    );
endinterface

// File: rtl/dac_sample_feed.sv
// Drains the read side of the sample FIFO at a fixed divided rate and turns
// each word into a DAC code, with prefill, underrun recovery and debug counters.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | disabled, DAC parked at midscale, no reads
//   S_PREFILL  | waiting for the FIFO to reach the prefill level
//   S_RUN      | one read per RATE_DIV cycles, word captured the cycle after
//   S_UNDERRUN | FIFO ran dry on a tick; one midscale cycle, then refill
module dac_sample_feed #(
    parameter int DATA_W     = 16,
    parameter int DAC_W      = 14,
    parameter int RATE_DIV   = 4,
    parameter int PREFILL    = 512,
    parameter int USEDW_W    = 11,
    parameter int OFFSET_BIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    dac_sample_feed_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_PREFILL  = 2'b01,
        S_RUN      = 2'b10,
        S_UNDERRUN = 2'b11
    } state_t;

    // Midscale doubles as the MSB flip mask: offset binary is two's complement with the sign bit inverted.
    localparam logic [DAC_W-1:0] MIDSCALE =
        (OFFSET_BIN != 0) ? {1'b1, {(DAC_W-1){1'b0}}} : {DAC_W{1'b0}};
    localparam logic [15:0] DIV_LAST    = 16'(RATE_DIV - 1);
    localparam logic [31:0] PREFILL_LVL = 32'(PREFILL);

    state_t           state;
    state_t           state_next;
    logic [15:0]      divider;
    logic [15:0]      divider_next;
    logic             rd_pending;
    logic             tick;
    logic             rdreq_c;
    logic             capture;
    logic             underrun_inc;
    logic             prefill_ok;
    logic [DAC_W-1:0] dac_data_q;
    logic [15:0]      underrun_q;
    logic [31:0]      sample_q;

    always_comb begin
        state_next   = state;
        rdreq_c      = 1'b0;
        underrun_inc = 1'b0;
        tick         = (state == S_RUN) && (divider == DIV_LAST);
        capture      = rd_pending && bus.enable;
        prefill_ok   = {{(32-USEDW_W){1'b0}}, bus.rdusedw} >= PREFILL_LVL;

        if (!bus.enable) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_next = S_PREFILL;
                S_PREFILL: if (prefill_ok) state_next = S_RUN;
                S_RUN: begin
                    if (tick) begin
                        if (bus.rdempty) begin
                            state_next   = S_UNDERRUN;
                            underrun_inc = 1'b1;
                        end else begin
                            rdreq_c = 1'b1;
                        end
                    end
                end
                S_UNDERRUN: state_next = S_PREFILL;
                default:    state_next = S_IDLE;
            endcase
        end

        // Divider restarts from zero on every entry to RUN and rests at zero elsewhere.
        divider_next = '0;
        if (state == S_RUN && state_next == S_RUN)
            divider_next = tick ? 16'd0 : divider + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            divider    <= '0;
            rd_pending <= 1'b0;
            dac_data_q <= MIDSCALE;
            underrun_q <= '0;
            sample_q   <= '0;
        end else begin
            state      <= state_next;
            divider    <= divider_next;
            rd_pending <= rdreq_c;

            if (capture) begin
                dac_data_q <= bus.q[DATA_W-1 -: DAC_W] ^ MIDSCALE;
                sample_q   <= sample_q + 32'd1;
            end else if (state_next == S_IDLE || state_next == S_UNDERRUN) begin
                dac_data_q <= MIDSCALE;
            end

            if (underrun_inc && underrun_q != 16'hFFFF)
                underrun_q <= underrun_q + 16'd1;
        end
    end

    assign bus.rdreq        = rdreq_c;
    assign bus.dac_valid    = capture;
    assign bus.dac_data     = dac_data_q;
    assign bus.feed_state   = state;
    assign bus.underrun_cnt = underrun_q;
    assign bus.sample_cnt   = sample_q;
endmodule

// File: tb/tb_dac_sample_feed.sv
// Self-checking bench for dac_sample_feed: a queue-based FIFO, a cycle model
// built from the pacing rules, a code table, and hand-written corner sequences.
module tb_dac_sample_feed;
    localparam int RD = 4;
    localparam int PF = 8;

    typedef struct {
        logic [15:0] word;
        logic [13:0] code_ob;
        logic [13:0] code_tc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable;
    logic rdempty;
    logic [10:0] rdusedw;
    logic [15:0] q;

    dac_sample_feed_if bus_ob ();
    dac_sample_feed_if bus_tc ();

    assign bus_ob.enable  = enable;
    assign bus_ob.rdempty = rdempty;
    assign bus_ob.rdusedw = rdusedw;
    assign bus_ob.q       = q;
    assign bus_tc.enable  = enable;
    assign bus_tc.rdempty = rdempty;
    assign bus_tc.rdusedw = rdusedw;
    assign bus_tc.q       = q;

    dac_sample_feed #(.PREFILL(PF), .RATE_DIV(RD), .OFFSET_BIN(1)) dut_ob (
        .clk(clk), .rst(rst), .bus(bus_ob.slave));
    dac_sample_feed #(.PREFILL(PF), .RATE_DIV(RD), .OFFSET_BIN(0)) dut_tc (
        .clk(clk), .rst(rst), .bus(bus_tc.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        en_req;
    logic        ov;
    logic        ov_empty;
    logic [10:0] ov_usedw;
    logic [15:0] q_word;
    logic [15:0] fq[$];

    vec_t tbl[8];
    bit   tbl_on;
    int   tbl_i;

    int          m_state;
    int          run_age;
    bit          m_pending;
    bit          m_rdreq;
    bit          m_cap_prev;
    logic [13:0] m_ob;
    logic [13:0] m_tc;
    logic [15:0] m_under;
    logic [31:0] m_samples;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed word, arithmetic-shifted down to 14 bits; offset binary adds half scale.
    function automatic logic [13:0] code_of(input logic [15:0] w, input bit ob);
        int s;
        s = $signed(w);
        s = s >>> 2;
        if (ob) s = s + 8192;
        s = s & 32'h3FFF;
        return s[13:0];
    endfunction

    task automatic model_reset();
        m_state    = 0;
        run_age    = 0;
        m_pending  = 0;
        m_rdreq    = 0;
        m_cap_prev = 0;
        m_ob       = 14'h2000;
        m_tc       = 14'h0000;
        m_under    = 16'h0;
        m_samples  = 32'h0;
    endtask

    task automatic step();
        bit tick;
        bit capture;
        int nxt;
        @(negedge clk);
        enable = en_req;
        if (ov) begin
            rdempty = ov_empty;
            rdusedw = ov_usedw;
        end else begin
            rdempty = (fq.size() == 0);
            rdusedw = (fq.size() > 2047) ? 11'd2047 : 11'(fq.size());
        end
        q = q_word;
        #1;
        tick    = (m_state == 2) && (run_age % RD == RD - 1);
        m_rdreq = tick && enable && !rdempty;
        capture = m_pending && enable;

        chk("rdreq", bus_ob.rdreq, m_rdreq);
        chk("rdreq_tc", bus_tc.rdreq, m_rdreq);
        chk("feed_state", bus_ob.feed_state, m_state);
        chk("dac_valid", bus_ob.dac_valid, capture);
        chk("dac_data", bus_ob.dac_data, m_ob);
        chk("dac_data_tc", bus_tc.dac_data, m_tc);
        chk("underrun_cnt", bus_ob.underrun_cnt, m_under);
        chk("sample_cnt", bus_ob.sample_cnt, m_samples);
        if (tbl_on && m_cap_prev && tbl_i < 8) begin
            chk("table_ob", bus_ob.dac_data, tbl[tbl_i].code_ob);
            chk("table_tc", bus_tc.dac_data, tbl[tbl_i].code_tc);
            tbl_i++;
        end

        if (!enable) nxt = 0;
        else begin
            case (m_state)
                0:       nxt = 1;
                1:       nxt = (rdusedw >= PF) ? 2 : 1;
                2:       nxt = (tick && rdempty) ? 3 : 2;
                default: nxt = 1;
            endcase
        end
        if (m_state == 2 && enable && tick && rdempty && m_under != 16'hFFFF) m_under++;
        if (capture) begin
            m_ob = code_of(q, 1'b1);
            m_tc = code_of(q, 1'b0);
            m_samples++;
        end else if (nxt == 0 || nxt == 3) begin
            m_ob = 14'h2000;
            m_tc = 14'h0000;
        end
        m_cap_prev = capture;
        m_pending  = m_rdreq;
        run_age    = (m_state == 2 && nxt == 2) ? run_age + 1 : 0;
        m_state    = nxt;
        if (m_rdreq) q_word = fq.pop_front();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  r0, f0, f1, v0;
        bit  found, saw_prefill, saw_under;
        logic [31:0] saved;

        tbl[0] = '{16'h8004, 14'h0001, 14'h2001};
        tbl[1] = '{16'h7FFC, 14'h3FFF, 14'h1FFF};
        tbl[2] = '{16'h0000, 14'h2000, 14'h0000};
        tbl[3] = '{16'hFFFF, 14'h1FFF, 14'h3FFF};
        tbl[4] = '{16'h0004, 14'h2001, 14'h0001};
        tbl[5] = '{16'h8000, 14'h0000, 14'h2000};
        tbl[6] = '{16'h7FFF, 14'h3FFF, 14'h1FFF};
        tbl[7] = '{16'h1234, 14'h248D, 14'h048D};

        en_req = 0; enable = 0; ov = 0; ov_empty = 1; ov_usedw = 0;
        q_word = 0; rdempty = 1; rdusedw = 0; q = 0; tbl_on = 0; tbl_i = 0;
        model_reset();

        // Reset values
        @(posedge clk); #1;
        chk("rst_rdreq", bus_ob.rdreq, 0);
        chk("rst_valid", bus_ob.dac_valid, 0);
        chk("rst_dac_data", bus_ob.dac_data, 14'h2000);
        chk("rst_dac_data_tc", bus_tc.dac_data, 14'h0000);
        chk("rst_state", bus_ob.feed_state, 0);
        chk("rst_underrun", bus_ob.underrun_cnt, 0);
        chk("rst_samples", bus_ob.sample_cnt, 0);
        rst = 0;

        // Prefill of 8 table words, stream them out, then underrun
        foreach (tbl[i]) fq.push_back(tbl[i].word);
        en_req = 1; tbl_on = 1;
        r0 = -1; f0 = -1; f1 = -1; v0 = -1; saw_under = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus_ob.feed_state == 2'd2 && r0 < 0) r0 = i;
            if (bus_ob.rdreq) begin
                if (f0 < 0) f0 = i;
                else if (f1 < 0) f1 = i;
            end
            if (bus_ob.dac_valid && v0 < 0) v0 = i;
            if (bus_ob.feed_state == 2'd3) begin
                saw_under = 1;
                chk("underrun_midscale", bus_ob.dac_data, 14'h2000);
            end
        end
        tbl_on = 0;
        chk("first_rdreq_delay", f0 - r0, 3);
        chk("rdreq_period", f1 - f0, RD);
        chk("valid_after_rdreq", v0 - f0, 1);
        chk("table_samples_seen", tbl_i, 8);
        chk("drain_sample_cnt", bus_ob.sample_cnt, 8);
        chk("drain_underrun_cnt", bus_ob.underrun_cnt, 1);
        chk("drain_saw_underrun", saw_under, 1);
        chk("drain_parked_prefill", bus_ob.feed_state, 1);

        // Enable dropped the cycle after a read request
        for (int i = 0; i < 12; i++) fq.push_back(16'($urandom));
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = m_rdreq;
        end
        chk("drop_rdreq_seen", found, 1);
        saved = m_samples;
        en_req = 0;
        step();
        chk("drop_no_valid", bus_ob.dac_valid, 0);
        step();
        chk("drop_state_idle", bus_ob.feed_state, 0);
        chk("drop_dac_mid", bus_ob.dac_data, 14'h2000);
        chk("drop_samples_kept", bus_ob.sample_cnt, saved);
        en_req = 1; saw_prefill = 0; found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (bus_ob.feed_state == 2'd1) saw_prefill = 1;
            found = (bus_ob.feed_state == 2'd2);
        end
        chk("reenable_via_prefill", saw_prefill && found, 1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (en_req) begin
                if ($urandom_range(99) < 2) en_req = 0;
            end else if ($urandom_range(99) < 25) en_req = 1;
            if (fq.size() < 24 && $urandom_range(99) < 22) fq.push_back(16'($urandom));
            step();
        end

        // Underrun counter saturation: preset near the top, then keep underrunning
        en_req = 1;
        for (int i = 0; i < 20; i++) step();
        fq.delete();
        ov = 1; ov_empty = 1;
        #1;
        force dut_ob.underrun_q = 16'hFFFA;
        #1;
        release dut_ob.underrun_q;
        m_under = 16'hFFFA;
        for (int i = 0; i < 100; i++) begin
            ov_usedw = (i % 3 == 0) ? 11'd3 : 11'd8 + 11'($urandom_range(100));
            step();
        end
        chk("underrun_saturated", bus_ob.underrun_cnt, 16'hFFFF);
        ov = 0;

        // Reset asserted while a read is pending
        for (int i = 0; i < 12; i++) fq.push_back(16'($urandom));
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = m_rdreq;
        end
        chk("rst_rdreq_seen", found, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_rdreq", bus_ob.rdreq, 0);
        chk("midrst_valid", bus_ob.dac_valid, 0);
        chk("midrst_dac_data", bus_ob.dac_data, 14'h2000);
        chk("midrst_state", bus_ob.feed_state, 0);
        chk("midrst_underrun", bus_ob.underrun_cnt, 0);
        chk("midrst_samples", bus_ob.sample_cnt, 0);
        @(posedge clk); #1;
        model_reset();
        rst = 0;
        for (int i = 0; i < 40; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
